// File: rtl/shield_evict_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shield_evict_buffer_pkg
//  Brief    : Shared types and default widths for the shield eviction buffer.
//  Revision : 1.0  initial release
// ============================================================================
package shield_evict_buffer_pkg;

    localparam int EVICT_ADDR_W   = 32;
    localparam int EVICT_LINE_W   = 512;
    localparam int EVICT_OFFSET_W = 6;
    localparam int EVICT_DEPTH    = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DRAIN = 2'd2
    } evict_state_e;

    typedef struct packed {
        logic [EVICT_ADDR_W-1:0] addr;
        logic [EVICT_LINE_W-1:0] data;
    } evict_entry_t;

endpackage
`default_nettype wire

// File: rtl/shield_evict_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : shield_evict_buffer_if
//  Brief    : Eviction, write-master, lookup and flush signals of the buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface shield_evict_buffer_if
    import shield_evict_buffer_pkg::*;
#(
    parameter int SHIELD_ADDR_WIDTH = EVICT_ADDR_W,
    parameter int LINE_WIDTH        = EVICT_LINE_W,
    parameter int DEPTH             = EVICT_DEPTH
);
    localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

    logic [LINE_WIDTH-1:0]        evict_data;
    logic [SHIELD_ADDR_WIDTH-1:0] evict_addr;
    logic                         evict_val;
    logic                         evict_rdy;

    logic [LINE_WIDTH-1:0]        wr_req_data;
    logic [SHIELD_ADDR_WIDTH-1:0] wr_req_addr;
    logic                         wr_req_val;
    logic                         wr_req_rdy;
    logic                         wr_busy;

    logic [SHIELD_ADDR_WIDTH-1:0] lookup_addr;
    logic                         lookup_val;
    logic                         lookup_hit;
    logic [LINE_WIDTH-1:0]        lookup_data;

    logic                         flush_req;
    logic                         flush_done;
    logic [COUNT_WIDTH-1:0]       count;

    // Environment side: cache eviction port, write master and read path.
    modport master (
        output evict_data, evict_addr, evict_val,
        input  evict_rdy,
        input  wr_req_data, wr_req_addr, wr_req_val,
        output wr_req_rdy, wr_busy,
        output lookup_addr, lookup_val,
        input  lookup_hit, lookup_data,
        output flush_req,
        input  flush_done, count
    );

    modport slave (
        input  evict_data, evict_addr, evict_val,
        output evict_rdy,
        output wr_req_data, wr_req_addr, wr_req_val,
        input  wr_req_rdy, wr_busy,
        input  lookup_addr, lookup_val,
        output lookup_hit, lookup_data,
        input  flush_req,
        output flush_done, count
    );

endinterface
`default_nettype wire

// File: rtl/shield_evict_cam.sv
`default_nettype none
// ============================================================================
//  Module   : shield_evict_cam
//  Brief    : Entry valid vector plus line-tag compare; reports the youngest
//             matching entry, searching from wr_ptr-1 back towards rd_ptr.
//  Revision : 1.0  initial release
// ============================================================================
module shield_evict_cam
#(
    parameter int   DEPTH     = 4,
    parameter int   TAG_WIDTH = 26,
    localparam int  PTR_W     = $clog2(DEPTH)
)(
    input  wire logic                            clk,
    input  wire logic                            rst_n,
    input  wire logic                            push,
    input  wire logic                            pop,
    input  wire logic [PTR_W-1:0]                wr_ptr,
    input  wire logic [PTR_W-1:0]                rd_ptr,
    input  wire logic [DEPTH-1:0][TAG_WIDTH-1:0] tags,
    input  wire logic [TAG_WIDTH-1:0]            probe,
    output logic                                 hit,
    output logic [PTR_W-1:0]                     hit_idx
);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match;
    logic [PTR_W-1:0] idx;

    // Push and pop never target the same slot: that needs count 0 or DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (push) valid[wr_ptr] <= 1'b1;
            if (pop)  valid[rd_ptr] <= 1'b0;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match[i] = valid[i] && (tags[i] == probe);
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = wr_ptr - PTR_W'(k);
            if (!hit && match[idx]) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shield_evict_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : shield_evict_buffer
//  Brief    : Dirty-line eviction queue feeding the shield write master; holds
//             each entry until its write retires for read-after-evict checks.
//             SHIELD_EVICT_FWD_EN: forward the matching line on lookup_data.
//  Revision : 1.0  initial release
// ============================================================================
module shield_evict_buffer
    import shield_evict_buffer_pkg::*;
#(
    parameter int SHIELD_ADDR_WIDTH = EVICT_ADDR_W,
    parameter int LINE_WIDTH        = EVICT_LINE_W,
    parameter int OFFSET_WIDTH      = EVICT_OFFSET_W,
    parameter int DEPTH             = EVICT_DEPTH
)(
    input  wire logic            clk,
    input  wire logic            rst_n,
    shield_evict_buffer_if.slave bus
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam int               TAG_W = SHIELD_ADDR_WIDTH - OFFSET_WIDTH;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    evict_entry_t                mem [DEPTH];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [CNT_W-1:0]            count;
    logic [CNT_W-1:0]            count_nxt;
    evict_state_e                state;
    logic                        req_val;
    logic                        done;
    logic                        rdy;
    logic                        push;
    logic                        pop;
    logic [DEPTH-1:0][TAG_W-1:0] tags;
    logic                        cam_hit;
    logic [PTR_W-1:0]            hit_idx;
    logic                        lookup_hit;

    assign rdy       = (count != FULL);
    assign push      = bus.evict_val && rdy;
    assign pop       = (state == S_DRAIN) && !bus.wr_busy;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: bus.evict_addr, data: bus.evict_data};
        end
    end

    // wr_req_val and flush_done are registered from next-cycle state/count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            req_val <= 1'b0;
            done    <= 1'b1;
        end else begin
            count <= count_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case (state)
                S_IDLE: begin
                    if (req_val && bus.wr_req_rdy) begin
                        state   <= S_START;
                        req_val <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        req_val <= (count_nxt != '0);
                        done    <= (count_nxt == '0);
                    end
                end
                S_START: begin
                    state   <= S_DRAIN;
                    req_val <= 1'b0;
                    done    <= 1'b0;
                end
                S_DRAIN: begin
                    if (!bus.wr_busy) begin
                        state   <= S_IDLE;
                        req_val <= (count_nxt != '0);
                        done    <= (count_nxt == '0);
                    end else begin
                        req_val <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    req_val <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_tags
        assign tags[i] = mem[i].addr[SHIELD_ADDR_WIDTH-1:OFFSET_WIDTH];
    end

    shield_evict_cam #(
        .DEPTH     (DEPTH),
        .TAG_WIDTH (TAG_W)
    ) u_cam (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .tags    (tags),
        .probe   (bus.lookup_addr[SHIELD_ADDR_WIDTH-1:OFFSET_WIDTH]),
        .hit     (cam_hit),
        .hit_idx (hit_idx)
    );

    assign lookup_hit      = bus.lookup_val && cam_hit;
    assign bus.lookup_hit  = lookup_hit;
    assign bus.evict_rdy   = rdy;
    assign bus.wr_req_val  = req_val;
    assign bus.wr_req_addr = mem[rd_ptr].addr;
    assign bus.wr_req_data = mem[rd_ptr].data;
    assign bus.flush_done  = done;
    assign bus.count       = count;

`ifdef SHIELD_EVICT_FWD_EN
    assign bus.lookup_data = lookup_hit ? mem[hit_idx].data : '0;
    logic unused_sig;
    assign unused_sig = &{1'b0, bus.flush_req, bus.lookup_addr[OFFSET_WIDTH-1:0]};
`else
    // Without forwarding the read path stalls on lookup_hit instead.
    assign bus.lookup_data = '0;
    logic unused_sig;
    assign unused_sig = &{1'b0, bus.flush_req, bus.lookup_addr[OFFSET_WIDTH-1:0], hit_idx};
`endif

endmodule
`default_nettype wire

// File: tb/tb_shield_evict_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shield_evict_buffer
//  Brief    : Directed self-checking bench for shield_evict_buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shield_evict_buffer;

    localparam int AW    = 32;
    localparam int LW    = 512;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [AW-1:0] q_addr [$];

    always #5 clk = ~clk;

    shield_evict_buffer_if #(.SHIELD_ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(DEPTH)) bus ();

    shield_evict_buffer #(
        .SHIELD_ADDR_WIDTH (AW),
        .LINE_WIDTH        (LW),
        .OFFSET_WIDTH      (6),
        .DEPTH             (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
        return {16{seed ^ 32'hA5C3_0000}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [AW-1:0] a);
        bus.evict_addr = a;
        bus.evict_data = mk_line(a);
        bus.evict_val  = 1'b1;
        tick();
        bus.evict_val  = 1'b0;
        q_addr.push_back(a);
    endtask

    // One full write-master transaction; optional enqueue on the popping edge.
    task automatic dispatch(input bit do_push, input logic [AW-1:0] a);
        bus.wr_req_rdy = 1'b1;
        tick();
        bus.wr_req_rdy = 1'b0;
        bus.wr_busy    = 1'b1;
        tick();
        bus.wr_busy    = 1'b0;
        if (do_push) begin
            bus.evict_addr = a;
            bus.evict_data = mk_line(a);
            bus.evict_val  = 1'b1;
        end
        tick();
        bus.evict_val = 1'b0;
        void'(q_addr.pop_front());
        if (do_push) q_addr.push_back(a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        bus.lookup_addr = 32'h0000_1040;
        bus.lookup_val  = 1'b1;
        #1;
        checks++; if (bus.evict_rdy !== 1'b1) begin errors++; $display("FAIL reset_evict_rdy: got %b expected 1", bus.evict_rdy); end
        checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL reset_flush_done: got %b expected 1", bus.flush_done); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.wr_req_val !== 1'b0) begin errors++; $display("FAIL reset_wr_req_val: got %b expected 0", bus.wr_req_val); end
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL reset_lookup_hit: got %b expected 0", bus.lookup_hit); end
        checks++; if (bus.lookup_data !== '0) begin errors++; $display("FAIL reset_lookup_data: got %h expected 0", bus.lookup_data); end
        bus.lookup_val = 1'b0;
    endtask

    task automatic test_single();
        enqueue(32'h0000_1040);
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count); end
        checks++; if (bus.wr_req_val !== 1'b1) begin errors++; $display("FAIL single_wr_req_val: got %b expected 1", bus.wr_req_val); end
        checks++; if (bus.wr_req_addr !== 32'h0000_1040) begin errors++; $display("FAIL single_wr_req_addr: got %h expected 00001040", bus.wr_req_addr); end
        checks++; if (bus.wr_req_data !== mk_line(32'h0000_1040)) begin errors++; $display("FAIL single_wr_req_data: got %h", bus.wr_req_data); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL single_flush_done: got %b expected 0", bus.flush_done); end
        bus.wr_req_rdy = 1'b1;
        tick();
        bus.wr_req_rdy = 1'b0;
        bus.wr_busy    = 1'b1;
        checks++; if (bus.wr_req_val !== 1'b0) begin errors++; $display("FAIL single_val_after_hs: got %b expected 0", bus.wr_req_val); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_busy_count[%0d]: got %0d expected 1", i, bus.count); end
        end
        bus.wr_busy     = 1'b0;
        bus.lookup_addr = 32'h0000_1040;
        bus.lookup_val  = 1'b1;
        #1;
        checks++; if (bus.lookup_hit !== 1'b1) begin errors++; $display("FAIL single_hit_pop_cycle: got %b expected 1", bus.lookup_hit); end
        tick();
        void'(q_addr.pop_front());
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL single_count_popped: got %0d expected 0", bus.count); end
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL single_hit_after_pop: got %b expected 0", bus.lookup_hit); end
        checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL single_flush_done_end: got %b expected 1", bus.flush_done); end
        checks++; if (bus.wr_req_val !== 1'b0) begin errors++; $display("FAIL single_val_end: got %b expected 0", bus.wr_req_val); end
        bus.lookup_val = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) enqueue(32'h0000_5000 + 32'(i) * 32'h40);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.count); end
        checks++; if (bus.evict_rdy !== 1'b0) begin errors++; $display("FAIL full_evict_rdy: got %b expected 0", bus.evict_rdy); end
        bus.evict_addr = 32'h0000_5100;
        bus.evict_data = mk_line(32'h0000_5100);
        bus.evict_val  = 1'b1;
        tick();
        tick();
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_fifth_held: got %0d expected 4", bus.count); end
        bus.wr_req_rdy = 1'b1;
        tick();
        bus.wr_req_rdy = 1'b0;
        bus.wr_busy    = 1'b1;
        tick();
        bus.wr_busy    = 1'b0;
        tick();
        void'(q_addr.pop_front());
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL full_after_pop: got %0d expected 3", bus.count); end
        checks++; if (bus.evict_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop: got %b expected 1", bus.evict_rdy); end
        tick();
        bus.evict_val = 1'b0;
        q_addr.push_back(32'h0000_5100);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_fifth_in: got %0d expected 4", bus.count); end
        checks++; if (bus.wr_req_addr !== 32'h0000_5040) begin errors++; $display("FAIL full_head: got %h expected 00005040", bus.wr_req_addr); end
        repeat (4) dispatch(1'b0, '0);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d expected 0", bus.count); end
        checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL full_flush_done: got %b expected 1", bus.flush_done); end
    endtask

    task automatic test_lookup();
        logic [LW-1:0] exp_b;
        logic [LW-1:0] exp_c;
`ifdef SHIELD_EVICT_FWD_EN
        exp_b = mk_line(32'h0000_2010);
        exp_c = mk_line(32'h0000_2400);
`else
        exp_b = '0;
        exp_c = '0;
`endif
        enqueue(32'h0000_2000);
        enqueue(32'h0000_2010);
        enqueue(32'h0000_2400);
        bus.lookup_val  = 1'b1;
        bus.lookup_addr = 32'h0000_2030;
        #1;
        checks++; if (bus.lookup_hit !== 1'b1) begin errors++; $display("FAIL lookup_2030_hit: got %b expected 1", bus.lookup_hit); end
        checks++; if (bus.lookup_data !== exp_b) begin errors++; $display("FAIL lookup_2030_data: got %h expected %h", bus.lookup_data, exp_b); end
        bus.lookup_addr = 32'h0000_2400;
        #1;
        checks++; if (bus.lookup_data !== exp_c) begin errors++; $display("FAIL lookup_2400_data: got %h expected %h", bus.lookup_data, exp_c); end
        bus.lookup_addr = 32'h0000_2040;
        #1;
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_2040_hit: got %b expected 0", bus.lookup_hit); end
        checks++; if (bus.lookup_data !== '0) begin errors++; $display("FAIL lookup_2040_data: got %h expected 0", bus.lookup_data); end
        bus.lookup_val  = 1'b0;
        bus.lookup_addr = 32'h0000_2000;
        #1;
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_val_low: got %b expected 0", bus.lookup_hit); end
        repeat (3) dispatch(1'b0, '0);
        bus.lookup_val = 1'b1;
        #1;
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_stale: got %b expected 0", bus.lookup_hit); end
        bus.lookup_val = 1'b0;
    endtask

    task automatic test_back_to_back();
        enqueue(32'h0000_3000);
        enqueue(32'h0000_3040);
        for (int k = 0; k < 8; k++) begin
            dispatch(1'b1, 32'h0000_4000 + 32'(k) * 32'h40);
            checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", k, bus.count); end
            checks++; if (bus.wr_req_addr !== q_addr[0]) begin errors++; $display("FAIL b2b_head[%0d]: got %h expected %h", k, bus.wr_req_addr, q_addr[0]); end
        end
        checks++; if (bus.wr_req_data !== mk_line(q_addr[0])) begin errors++; $display("FAIL b2b_head_data: got %h", bus.wr_req_data); end
        dispatch(1'b0, '0);
        dispatch(1'b1, 32'h0000_6000);
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL empty_refill_count: got %0d expected 1", bus.count); end
        checks++; if (bus.wr_req_val !== 1'b1) begin errors++; $display("FAIL empty_refill_val: got %b expected 1", bus.wr_req_val); end
        checks++; if (bus.wr_req_addr !== 32'h0000_6000) begin errors++; $display("FAIL empty_refill_addr: got %h expected 00006000", bus.wr_req_addr); end
        dispatch(1'b0, '0);
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d expected 0", bus.count); end
    endtask

    task automatic test_reset_mid();
        enqueue(32'h0000_7000);
        enqueue(32'h0000_7040);
        enqueue(32'h0000_7080);
        bus.wr_req_rdy = 1'b1;
        tick();
        bus.wr_req_rdy = 1'b0;
        bus.wr_busy    = 1'b1;
        tick();
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", bus.count); end
        rst_n = 1'b0;
        tick();
        rst_n          = 1'b1;
        bus.wr_busy    = 1'b0;
        bus.lookup_addr = 32'h0000_7000;
        bus.lookup_val  = 1'b1;
        #1;
        q_addr.delete();
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", bus.count); end
        checks++; if (bus.wr_req_val !== 1'b0) begin errors++; $display("FAIL rstmid_wr_req_val: got %b expected 0", bus.wr_req_val); end
        checks++; if (bus.lookup_hit !== 1'b0) begin errors++; $display("FAIL rstmid_lookup_hit: got %b expected 0", bus.lookup_hit); end
        checks++; if (bus.flush_done !== 1'b1) begin errors++; $display("FAIL rstmid_flush_done: got %b expected 1", bus.flush_done); end
        bus.lookup_val = 1'b0;
    endtask

    initial begin
        bus.evict_data  = '0;
        bus.evict_addr  = '0;
        bus.evict_val   = 1'b0;
        bus.wr_req_rdy  = 1'b0;
        bus.wr_busy     = 1'b0;
        bus.lookup_addr = '0;
        bus.lookup_val  = 1'b0;
        bus.flush_req   = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_lookup();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shield_evict_buffer.md
# shield_evict_buffer

Queues dirty lines evicted by the shield cache and feeds them one at a time to the write master (encrypt, write ciphertext, write tag). Each entry is held from enqueue until its DRAM write and tag write fully retire, so the read path can detect read-after-evict hazards against any pending or in-flight line. It sits between the cache eviction port and the write master's `req_*`/`busy` interface.

## Interface
- `SHIELD_ADDR_WIDTH`, 32, byte address width.
- `LINE_WIDTH`, 512, cache line width in bits.
- `OFFSET_WIDTH`, 6, line offset bits; ignored in all address compares.
- `DEPTH`, 4, number of entries; power of two, at least 2.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `evict_data` in LINE_WIDTH: line to write back.
- `evict_addr` in SHIELD_ADDR_WIDTH: line address.
- `evict_val` in 1 / `evict_rdy` out 1: enqueue handshake.
- `wr_req_data` out LINE_WIDTH, `wr_req_addr` out SHIELD_ADDR_WIDTH: head entry.
- `wr_req_val` out 1 / `wr_req_rdy` in 1: handshake to the write master.
- `wr_busy` in 1: write master busy.
- `lookup_addr` in SHIELD_ADDR_WIDTH, `lookup_val` in 1: hazard probe from the read path.
- `lookup_hit` out 1: combinational; a valid entry matches the probe.
- `lookup_data` out LINE_WIDTH: line of the youngest matching entry.
- `flush_req` in 1 (level), `flush_done` out 1: drain request and drain status.
- `count` out $clog2(DEPTH+1): occupancy.

## Operation
- Circular buffer with `wr_ptr`, `rd_ptr` (each $clog2(DEPTH) bits, wrap modulo DEPTH) and `count`.
  - Enqueue when `evict_val && evict_rdy`.
  - `evict_rdy = (count != DEPTH)`. It does not depend on a same-cycle pop.
- Dispatch FSM:
  - **S_IDLE**: `wr_req_val = (count != 0)`. On `wr_req_val && wr_req_rdy`, go to S_START.
  - **S_START**: single guard cycle while `wr_busy` rises. `busy` is ignored here. Always go to S_DRAIN.
  - **S_DRAIN**: when `!wr_busy`, pop the head (`rd_ptr++`, `count--`) and go to S_IDLE.
- The head entry stays valid, and visible to lookup, until the pop.
- `wr_req_data`/`wr_req_addr` always show the head entry. They are held stable while `wr_req_val` is high.
- Lookup:
  - Compare `lookup_addr[SHIELD_ADDR_WIDTH-1:OFFSET_WIDTH]` against every valid entry.
  - `lookup_hit = lookup_val && any_match`.
  - When several entries match, the one nearest `wr_ptr` (youngest) wins.
  - `lookup_data` is 0 when there is no hit.
- Duplicate addresses are allowed. No coalescing; the entries drain in order.
- `flush_done = (count == 0) && state == S_IDLE`. `flush_req` does not block enqueue; it only tells the controller to stop evicting until done.

## Timing
- Reset values:
  - `count` 0, pointers 0, state S_IDLE.
  - `evict_rdy` 1 and `flush_done` 1 from the first cycle after reset.
  - `wr_req_val` 0, `lookup_hit` 0, `lookup_data` 0.
  - Entry storage is not reset.
- An enqueue at edge t is visible to lookup and to `wr_req_val` in cycle t+1 (registered storage).
- Minimum occupancy per entry: handshake cycle + S_START + the write master's busy period + 1.
- Simultaneous enqueue and pop: `count` is unchanged, both pointers advance.
- Enqueue into an empty buffer in the same cycle a pop empties it: legal; the new entry dispatches next cycle.
- Full (`count == DEPTH`): `evict_rdy = 0`. Pointers wrap cleanly.
- Lookup on the popping cycle still hits the popped entry. From the next cycle it does not.
- Reset mid-operation drops all entries. The write master must be reset in the same cycle.

## Configuration
- `SHIELD_EVICT_FWD_EN` defined: `lookup_data` forwards the matching line, and the read path may bypass DRAM.
- Undefined:
  - `lookup_data` is tied to 0 and the data mux is not built.
  - `lookup_hit` is still generated; the read path stalls until the hit clears.

## Structure
- The shared shield package holds the `evict_entry_t` struct (addr, data) and the state enum `evict_state_e`.
- One sub-module, `shield_evict_cam`: the valid vector plus address compare. It outputs the hit and the youngest-match index (priority from `wr_ptr` downward).

## Test plan
- Reset, then idle: `evict_rdy=1`, `flush_done=1`, `count=0`, `wr_req_val=0`.
- Enqueue addr 0x1040, then hold `wr_busy=1` for 10 cycles:
  - `wr_req_val` rises the next cycle.
  - After the handshake, `count` stays 1 until `wr_busy` falls, then goes to 0.
- Enqueue 4 lines with `wr_req_rdy=0`: `count=4` and `evict_rdy=0`. The 5th evict is held until the first pop.
- Enqueue 0x2000 (data A) then 0x2010 (data B), and probe 0x2030:
  - `lookup_hit=1`.
  - `lookup_data=B` with FWD_EN; 0 without it.
- Probe 0x2040 with no such entry: `lookup_hit=0`.
- Enqueue and pop in the same cycle at `count=2`: `count` stays 2. Pointers wrap after 8 such cycles.
- Assert reset while in S_DRAIN with `count=3`: next cycle `count=0`, `wr_req_val=0`, `lookup_hit=0`.
